// File: rtl/alu_ctrl_pkg.sv
// Shared types, opcodes and IR field positions for the alu_ctrl_seq hardwired control unit.
package alu_ctrl_pkg;

    localparam int OP_W = 5;

    // IR field bit positions
    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01010;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b01011;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b01100;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    // Every control output of the sequencer, grouped so decode fills one value.
    typedef struct packed {
        logic            pc_out;
        logic            mar_in;
        logic            inc_pc;
        logic            pc_in;
        logic            read;
        logic            mdr_in;
        logic            mdr_out;
        logic            ir_in;
        logic            y_in;
        logic            z_in;
        logic            zlow_out;
        logic            zhigh_out;
        logic            lo_in;
        logic            hi_in;
        logic            gra;
        logic            grb;
        logic            grc;
        logic            r_in;
        logic            r_out;
        logic            run;
        logic            illegal_op;
        logic [OP_W-1:0] opcode;
    } ctrl_t;

    function automatic logic is_hilo_op(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return ((op >= OP_ADD) && (op <= OP_NOT)) || is_hilo_op(op);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of the sequencer state and IR opcode into the control output bundle.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  state_t          state,
    input  logic [OP_W-1:0] op,
    output ctrl_t           ctrl
);

    always_comb begin
        // NOTE: default everything first so no path leaves a field unassigned (no latches).
        ctrl     = '0;
        ctrl.run = (state != S_RESET) && (state != S_HALT);
        case (state)
            S_T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.pc_in  = 1'b1;
            end
            S_T1: begin
                ctrl.read   = 1'b1;
                ctrl.mdr_in = 1'b1;
            end
            S_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            S_T3: begin
                if (is_alu_op(op)) begin
                    ctrl.grb   = 1'b1;
                    ctrl.r_out = 1'b1;
                    ctrl.y_in  = 1'b1;
                end else if ((op != OP_NOP) && (op != OP_HALT)) begin
                    ctrl.illegal_op = 1'b1;
                end
            end
            S_T4: begin
                ctrl.grc    = 1'b1;
                ctrl.r_out  = 1'b1;
                ctrl.z_in   = 1'b1;
                ctrl.opcode = op;
            end
            S_T5: begin
                ctrl.zlow_out = 1'b1;
                if (is_hilo_op(op)) begin
                    ctrl.lo_in = 1'b1;
                end else begin
                    ctrl.gra  = 1'b1;
                    ctrl.r_in = 1'b1;
                end
            end
            S_T6: begin
                ctrl.zhigh_out = 1'b1;
                ctrl.hi_in     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Hardwired fetch/ALU-execute sequencer; define MEM_WAIT_EN to stretch T1 until mem_ready.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic [31:0]      IR,
    input  logic             Stop,
    input  logic             mem_ready,
    output logic             PCout,
    output logic             MARin,
    output logic             IncPC,
    output logic             PCin,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             LOin,
    output logic             HIin,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic [OP_W-1:0]  opcode,
    output logic             run,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t          state;
    state_t          t0_or_halt;
    ctrl_t           ctrl;
    logic [OP_W-1:0] op;

    assign op         = IR[OP_HI:OP_LO];
    // Register fields feed select-and-encode directly; only the opcode matters here.
    logic unused_ir;
    assign unused_ir  = ^IR[RA_HI:0];
    assign t0_or_halt = Stop ? S_HALT : S_T0;

`ifndef MEM_WAIT_EN
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clock) begin
        if (clear) begin
            state       <= S_RESET;
            instr_count <= '0;
        end else begin
            case (state)
                S_RESET: state <= t0_or_halt;
                S_T0:    state <= S_T1;
`ifdef MEM_WAIT_EN
                S_T1:    if (mem_ready) state <= S_T2;
`else
                S_T1:    state <= S_T2;
`endif
                S_T2:    state <= S_T3;
                S_T3: begin
                    if (is_alu_op(op)) begin
                        state <= S_T4;
                    end else if (op == OP_HALT) begin
                        state <= S_HALT;
                    end else begin
                        if (op == OP_NOP) instr_count <= instr_count + 1'b1;
                        state <= t0_or_halt;
                    end
                end
                S_T4:    state <= S_T5;
                S_T5: begin
                    if (is_hilo_op(op)) begin
                        state <= S_T6;
                    end else begin
                        instr_count <= instr_count + 1'b1;
                        state       <= t0_or_halt;
                    end
                end
                S_T6: begin
                    instr_count <= instr_count + 1'b1;
                    state       <= t0_or_halt;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_RESET;
            endcase
        end
    end

    alu_ctrl_decode u_decode (
        .state (state),
        .op    (op),
        .ctrl  (ctrl)
    );

    assign PCout      = ctrl.pc_out;
    assign MARin      = ctrl.mar_in;
    assign IncPC      = ctrl.inc_pc;
    assign PCin       = ctrl.pc_in;
    assign Read       = ctrl.read;
    assign MDRin      = ctrl.mdr_in;
    assign MDRout     = ctrl.mdr_out;
    assign IRin       = ctrl.ir_in;
    assign Yin        = ctrl.y_in;
    assign Zin        = ctrl.z_in;
    assign Zlowout    = ctrl.zlow_out;
    assign Zhighout   = ctrl.zhigh_out;
    assign LOin       = ctrl.lo_in;
    assign HIin       = ctrl.hi_in;
    assign Gra        = ctrl.gra;
    assign Grb        = ctrl.grb;
    assign Grc        = ctrl.grc;
    assign Rin        = ctrl.r_in;
    assign Rout       = ctrl.r_out;
    assign opcode     = ctrl.opcode;
    assign run        = ctrl.run;
    assign illegal_op = ctrl.illegal_op;

endmodule
